// File: rtl/sub_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives requests and operands; the slave returns results.
interface sub_serial_if;
    logic       START;
    logic [3:0] A_DATA;
    logic [3:0] B_DATA;
    logic [5:0] SUB_DATA;
    logic       NEG;
    logic       BUSY;
    logic       DONE;

    modport master (
        output START,
        output A_DATA,
        output B_DATA,
        input  SUB_DATA,
        input  NEG,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  START,
        input  A_DATA,
        input  B_DATA,
        output SUB_DATA,
        output NEG,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial 4-bit subtractor, LSB first, registered borrow, 6-bit result.
// Define SUB_SERIAL_ABS_EN to return |A-B| through an extra ABS state.
module sub_serial (
    input logic        CLK,
    input logic        RST,
    sub_serial_if.slave bus
);

`ifdef SUB_SERIAL_ABS_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ABS,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;
`endif

    state_t     state;
    state_t     state_nxt;

    logic [3:0] a_sr;
    logic [3:0] b_sr;
    logic [3:0] res_sr;
    logic [1:0] cnt;
    logic       borrow;
    logic [5:0] sub_q;
    logic       neg_q;

    logic       load;
    logic       shift;
    logic       last;

    logic       d;
    logic       borrow_nxt;

    assign d          = a_sr[0] ^ b_sr[0] ^ borrow;
    assign borrow_nxt = (~a_sr[0] & b_sr[0])
                      | (~(a_sr[0] ^ b_sr[0]) & borrow);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        last      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.START) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift = 1'b1;
                if (cnt == 2'd3) begin
                    last = 1'b1;
`ifdef SUB_SERIAL_ABS_EN
                    state_nxt = S_ABS;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef SUB_SERIAL_ABS_EN
            S_ABS: begin
                state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                if (bus.START) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef SUB_SERIAL_ABS_EN
    // Raw 5-bit difference parked between the last shift and ABS.
    logic [4:0] raw;
    logic [3:0] mag;
    logic       fin_abs;

    assign fin_abs = (state == S_ABS);
    assign mag     = raw[4] ? (~raw[3:0] + 4'd1) : raw[3:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            raw <= 5'd0;
        end else if (last) begin
            raw <= {borrow_nxt, d, res_sr[3:1]};
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sr   <= 4'd0;
            b_sr   <= 4'd0;
            res_sr <= 4'd0;
            cnt    <= 2'd0;
            borrow <= 1'b0;
            sub_q  <= 6'h00;
            neg_q  <= 1'b0;
        end else begin
            if (load) begin
                a_sr   <= bus.A_DATA;
                b_sr   <= bus.B_DATA;
                cnt    <= 2'd0;
                borrow <= 1'b0;
            end
            if (shift) begin
                a_sr   <= {1'b0, a_sr[3:1]};
                b_sr   <= {1'b0, b_sr[3:1]};
                res_sr <= {d, res_sr[3:1]};
                borrow <= borrow_nxt;
                cnt    <= cnt + 2'd1;
            end
`ifdef SUB_SERIAL_ABS_EN
            if (fin_abs) begin
                sub_q <= {2'b00, mag};
                neg_q <= raw[4];
            end
`else
            if (last) begin
                sub_q <= {borrow_nxt, borrow_nxt,
                          d, res_sr[3:1]};
                neg_q <= borrow_nxt;
            end
`endif
        end
    end

    assign bus.SUB_DATA = sub_q;
    assign bus.NEG      = neg_q;
`ifdef SUB_SERIAL_ABS_EN
    assign bus.BUSY     = (state == S_SHIFT) || (state == S_ABS);
`else
    assign bus.BUSY     = (state == S_SHIFT);
`endif
    assign bus.DONE     = (state == S_DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: directed operands, queued expectations,
// DONE-driven monitor, plus latency, busy-ignore, back-to-back, reset cases.
module tb_sub_serial;

    logic clk;
    logic rst;

    sub_serial_if bus ();

    sub_serial dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SUB_SERIAL_ABS_EN
    localparam int LAT = 5;
    localparam logic [5:0] E_3_5  = 6'h02;
    localparam logic [5:0] E_0_15 = 6'h0F;
`else
    localparam int LAT = 4;
    localparam logic [5:0] E_3_5  = 6'h3E;
    localparam logic [5:0] E_0_15 = 6'h31;
`endif

    logic [6:0] exp_q [$];
    int cmp;
    int err;
    int done_cnt;

    // Monitor: every DONE pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [6:0] e;
        if (!rst && bus.DONE) begin
            done_cnt++;
            cmp++;
            if (exp_q.size() == 0) begin
                err++;
                $display("FAIL unexpected_done: got sub=%h neg=%b, wanted no DONE",
                         bus.SUB_DATA, bus.NEG);
            end else begin
                e = exp_q.pop_front();
                if ({bus.SUB_DATA, bus.NEG} !== e) begin
                    err++;
                    $display("FAIL result: got sub=%h neg=%b, wanted sub=%h neg=%b",
                             bus.SUB_DATA, bus.NEG, e[6:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    // Starts at the negedge after the accepting edge.
    task automatic wait_done(output int n, output int busy);
        n    = 0;
        busy = 0;
        while (!bus.DONE && n < 20) begin
            if (bus.BUSY) busy++;
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            cmp++;
            err++;
            $display("FAIL done_timeout: got no DONE in %0d cycles, wanted %0d", n, LAT);
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [5:0] sub, input logic neg);
        int n;
        int busy;
        bus.START  = 1'b1;
        bus.A_DATA = a;
        bus.B_DATA = b;
        exp_q.push_back({sub, neg});
        @(negedge clk);
        bus.START  = 1'b0;
        bus.A_DATA = 4'hx;
        bus.B_DATA = 4'hx;
        wait_done(n, busy);
        check("latency", n, LAT);
        check("busy_cycles", busy, LAT);
        @(negedge clk);
        check("done_one_cycle", int'(bus.DONE), 0);
    endtask

    initial begin
        int n;
        int busy;
        int d0;
        cmp        = 0;
        err        = 0;
        done_cnt   = 0;
        rst        = 1'b1;
        bus.START  = 1'b0;
        bus.A_DATA = 4'd0;
        bus.B_DATA = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_sub", int'(bus.SUB_DATA), 0);
        check("rst_neg", int'(bus.NEG), 0);
        check("rst_busy", int'(bus.BUSY), 0);
        check("rst_done", int'(bus.DONE), 0);
        repeat (6) @(negedge clk);
        check("idle_no_done", done_cnt, 0);

        issue(4'd9, 4'd4, 6'h05, 1'b0);
        issue(4'd3, 4'd5, E_3_5, 1'b1);
        issue(4'd0, 4'd15, E_0_15, 1'b1);
        issue(4'd15, 4'd0, 6'h0F, 1'b0);
        issue(4'd7, 4'd7, 6'h00, 1'b0);

        // START with new operands in the 2nd SHIFT cycle is ignored.
        d0 = done_cnt;
        bus.START  = 1'b1;
        bus.A_DATA = 4'd3;
        bus.B_DATA = 4'd5;
        exp_q.push_back({E_3_5, 1'b1});
        @(negedge clk);
        bus.START = 1'b0;
        @(negedge clk);
        bus.START  = 1'b1;
        bus.A_DATA = 4'd15;
        bus.B_DATA = 4'd0;
        @(negedge clk);
        bus.START = 1'b0;
        wait_done(n, busy);
        check("ignore_latency", n, LAT - 2);
        repeat (8) @(negedge clk);
        check("ignore_done_count", done_cnt - d0, 1);

        // Back-to-back: START held through the DONE cycle.
        bus.START  = 1'b1;
        bus.A_DATA = 4'd9;
        bus.B_DATA = 4'd4;
        exp_q.push_back({6'h05, 1'b0});
        @(negedge clk);
        bus.A_DATA = 4'd0;
        bus.B_DATA = 4'd15;
        exp_q.push_back({E_0_15, 1'b1});
        wait_done(n, busy);
        check("b2b_first_latency", n, LAT);
        @(negedge clk);
        check("b2b_done_drop", int'(bus.DONE), 0);
        check("b2b_busy", int'(bus.BUSY), 1);
        bus.START = 1'b0;
        wait_done(n, busy);
        check("b2b_period", n + 1, LAT + 1);
        @(negedge clk);

        // Reset in the 3rd SHIFT cycle discards the operation.
        d0 = done_cnt;
        bus.START  = 1'b1;
        bus.A_DATA = 4'd9;
        bus.B_DATA = 4'd4;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_sub", int'(bus.SUB_DATA), 0);
        check("mid_rst_neg", int'(bus.NEG), 0);
        check("mid_rst_busy", int'(bus.BUSY), 0);
        check("mid_rst_done", int'(bus.DONE), 0);
        repeat (8) @(negedge clk);
        check("mid_rst_no_done", done_cnt - d0, 0);
        issue(4'd3, 4'd5, E_3_5, 1'b1);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
